// File: rtl/arb_client_pkg.sv
// Shared types and constants for the arbiter client controller.
// State encoding, the queued-job record and the wait counter width live here
// so the controller, its FIFO and any environment agree on them.
package arb_client_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    // Width of the exported consecutive-wait counter.
    localparam int WAIT_W = 8;

    // Default job field widths; the controller parameters default to these.
    localparam int JOB_LEN_W  = 4;
    localparam int JOB_DATA_W = 8;

    typedef struct packed {
        logic [JOB_LEN_W-1:0]  len;
        logic [JOB_DATA_W-1:0] data;
    } job_t;

endpackage

// File: rtl/arb_client_ctrl_if.sv
// Job intake, arbiter handshake and beat output of one requester lane.
// master: the client controller. slave: the job source, arbiter and beat sink.
interface arb_client_ctrl_if #(
    parameter int LEN_W  = 4,
    parameter int DATA_W = 8
) ();

    logic                              job_valid;
    logic                              job_ready;
    logic [LEN_W-1:0]                  job_len;
    logic [DATA_W-1:0]                 job_data;
    logic                              arb_req;
    logic                              arb_gnt;
    logic                              xfer_valid;
    logic [DATA_W-1:0]                 xfer_data;
    logic                              xfer_last;
    logic                              busy;
    logic                              starve;
    logic [arb_client_pkg::WAIT_W-1:0] wait_cnt;

    modport master (
        input  job_valid, job_len, job_data, arb_gnt,
        output job_ready, arb_req, xfer_valid, xfer_data, xfer_last,
               busy, starve, wait_cnt
    );

    modport slave (
        output job_valid, job_len, job_data, arb_gnt,
        input  job_ready, arb_req, xfer_valid, xfer_data, xfer_last,
               busy, starve, wait_cnt
    );

endinterface

// File: rtl/arb_client_fifo.sv
// Synchronous job queue with count-based full/empty.
// A push while full is dropped even if a pop happens in the same cycle, so the
// producer only ever sees ready depend on the registered count.
module arb_client_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/arb_client_ctrl.sv
// Requester-side controller for the fixed-priority arbiter.
// Queues jobs, requests the bus, and emits one data beat per granted cycle.
// Grants may drop mid-burst; the beat counter simply holds until they return.
// Optional build macro ARB_CLIENT_STARVE_EN adds the wait counter and starve
// flag; without it wait_cnt and starve are tied low.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no job held; pops the FIFO head when one is queued
//   ACTIVE | request high; a beat on every cycle the grant is present
//   GAP    | one cycle with request low; swallows the arbiter's stale grant
module arb_client_ctrl
    import arb_client_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int LEN_W      = JOB_LEN_W,
    parameter int DATA_W     = JOB_DATA_W,
    parameter int STARVE_MAX = 15
) (
    input  logic              arb_clk,
    input  logic              arb_rst_n,
    arb_client_ctrl_if.master bus
);

    // One extra bit so a full 2^LEN_W-beat job never wraps before the compare.
    localparam int CNT_W = LEN_W + 1;

    state_t              state;
    state_t              state_nxt;
    logic                arb_req_q;
    logic                req_nxt;
    logic                pop;
    logic                beat;
    logic                last;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    beat_cnt;
    logic [LEN_W-1:0]    len_q;
    logic [DATA_W-1:0]   base_q;
    logic [LEN_W+DATA_W-1:0] head;

    arb_client_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LEN_W + DATA_W)
    ) u_fifo (
        .clk   (arb_clk),
        .rst_n (arb_rst_n),
        .push  (bus.job_valid),
        .pop   (pop),
        .din   ({bus.job_len, bus.job_data}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A grant only counts while our own registered request is up in ACTIVE.
    assign beat = (state == ACTIVE) && arb_req_q && bus.arb_gnt;
    assign last = (beat_cnt == {1'b0, len_q});

    assign bus.job_ready  = !fifo_full;
    assign bus.arb_req    = arb_req_q;
    assign bus.busy       = (state != IDLE);
    assign bus.xfer_valid = beat;
    assign bus.xfer_data  = beat ? (base_q + DATA_W'(beat_cnt)) : '0;
    assign bus.xfer_last  = beat && last;

    // Next-state, next-request and FIFO pop decisions.
    always_comb begin
        state_nxt = state;
        req_nxt   = arb_req_q;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                req_nxt = 1'b0;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    req_nxt   = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                req_nxt = 1'b1;
                if (beat && last) begin
                    req_nxt   = 1'b0;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                req_nxt   = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State, request and current-job registers; the job loads on the pop.
    always_ff @(posedge arb_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            state     <= IDLE;
            arb_req_q <= 1'b0;
            beat_cnt  <= '0;
            len_q     <= '0;
            base_q    <= '0;
        end else begin
            state     <= state_nxt;
            arb_req_q <= req_nxt;
            if (pop) begin
                beat_cnt <= '0;
                len_q    <= head[LEN_W+DATA_W-1:DATA_W];
                base_q   <= head[DATA_W-1:0];
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

`ifdef ARB_CLIENT_STARVE_EN
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(STARVE_MAX);

    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_nxt;
    logic              starve_q;
    logic              starve_nxt;

    // Saturating count of ungranted ACTIVE cycles; any beat or leaving ACTIVE clears it.
    always_comb begin
        wait_nxt   = '0;
        starve_nxt = 1'b0;
        if (state == ACTIVE && !beat) begin
            wait_nxt   = (wait_q == WAIT_SAT) ? wait_q : wait_q + 1'b1;
            starve_nxt = starve_q || (wait_nxt == WAIT_SAT);
        end
    end

    // Wait counter and sticky starve flag registers.
    always_ff @(posedge arb_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            wait_q   <= '0;
            starve_q <= 1'b0;
        end else begin
            wait_q   <= wait_nxt;
            starve_q <= starve_nxt;
        end
    end

    assign bus.wait_cnt = wait_q;
    assign bus.starve   = starve_q;
`else
    assign bus.wait_cnt = '0;
    assign bus.starve   = 1'b0;
`endif

endmodule

// File: tb/tb_arb_client_ctrl.sv
// Self-checking bench for arb_client_ctrl: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a queue-based model.
module tb_arb_client_ctrl;
    import arb_client_pkg::*;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 15;
`ifdef ARB_CLIENT_STARVE_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic arb_clk = 1'b0;
    logic arb_rst_n = 1'b0;
    always #5 arb_clk = ~arb_clk;

    arb_client_ctrl_if ifc ();

    arb_client_ctrl #(
        .DEPTH(DEPTH), .LEN_W(4), .DATA_W(8), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .arb_clk   (arb_clk),
        .arb_rst_n (arb_rst_n),
        .bus       (ifc)
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Apply inputs just after an edge and move to the mid-cycle sample point.
    task automatic drive(input bit v, input logic [3:0] l, input logic [7:0] d, input bit g);
        ifc.job_valid = v;
        ifc.job_len   = l;
        ifc.job_data  = d;
        ifc.arb_gnt   = g;
        #4;
    endtask

    task automatic step();
        @(posedge arb_clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    job_t mq[$];
    bit   m_act, m_gap;
    job_t m_cur;
    int   m_done, m_wait;
    bit   m_starve;

    function automatic void model_reset();
        mq.delete();
        m_act = 0; m_gap = 0; m_done = 0; m_wait = 0; m_starve = 0;
        m_cur = '0;
    endfunction

    task automatic model_check(input bit g);
        bit xv;
        xv = m_act && g;
        chk("m_arb_req", ifc.arb_req, m_act);
        chk("m_busy", ifc.busy, m_act || m_gap);
        chk("m_job_ready", ifc.job_ready, mq.size() < DEPTH);
        chk("m_xfer_valid", ifc.xfer_valid, xv);
        chk("m_xfer_data", ifc.xfer_data, xv ? ((int'(m_cur.data) + m_done) & 8'hFF) : 0);
        chk("m_xfer_last", ifc.xfer_last, xv && (m_done == int'(m_cur.len)));
        chk("m_wait_cnt", ifc.wait_cnt, SE ? m_wait : 0);
        chk("m_starve", ifc.starve, SE && m_starve);
    endtask

    function automatic void model_edge(input bit v, input logic [3:0] l, input logic [7:0] d, input bit g);
        bit   acc;
        job_t j;
        acc = v && (mq.size() < DEPTH);
        if (m_act) begin
            if (g) begin
                m_done++;
                m_wait = 0;
                m_starve = 0;
                if (m_done == int'(m_cur.len) + 1) begin
                    m_act = 0;
                    m_gap = 1;
                end
            end else begin
                if (m_wait < STARVE_MAX) m_wait++;
                if (m_wait == STARVE_MAX) m_starve = 1;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (mq.size() > 0) begin
            m_cur  = mq.pop_front();
            m_act  = 1;
            m_done = 0;
            m_wait = 0;
        end
        if (acc) begin
            j.len = l;
            j.data = d;
            mq.push_back(j);
        end
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         v;
        logic [3:0] len;
        logic [7:0] data;
        bit         gnt;
        bit         req;
        bit         xv;
        logic [7:0] xd;
        bit         xl;
        bit         busy;
        logic [7:0] wt;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int nb, req_cycles, stall, found;
        logic [7:0] bdata[$];
        bit         blast[$];

        ifc.job_valid = 0; ifc.job_len = 0; ifc.job_data = 0; ifc.arb_gnt = 0;

        // len=0 single beat with grant one cycle behind request, then len=3 wrap with grant held
        tbl[0]  = '{1, 4'd0, 8'h10, 0, 0, 0, 8'h00, 0, 0, 8'd0};
        tbl[1]  = '{0, 4'd0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0};
        tbl[2]  = '{0, 4'd0, 8'h00, 0, 1, 0, 8'h00, 0, 1, 8'd0};
        tbl[3]  = '{0, 4'd0, 8'h00, 1, 1, 1, 8'h10, 1, 1, SE ? 8'd1 : 8'd0};
        tbl[4]  = '{0, 4'd0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 8'd0};
        tbl[5]  = '{0, 4'd0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0};
        tbl[6]  = '{1, 4'd3, 8'hFE, 1, 0, 0, 8'h00, 0, 0, 8'd0};
        tbl[7]  = '{0, 4'd0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8'd0};
        tbl[8]  = '{0, 4'd0, 8'h00, 1, 1, 1, 8'hFE, 0, 1, 8'd0};
        tbl[9]  = '{0, 4'd0, 8'h00, 1, 1, 1, 8'hFF, 0, 1, 8'd0};
        tbl[10] = '{0, 4'd0, 8'h00, 1, 1, 1, 8'h00, 0, 1, 8'd0};
        tbl[11] = '{0, 4'd0, 8'h00, 1, 1, 1, 8'h01, 1, 1, 8'd0};
        tbl[12] = '{0, 4'd0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 8'd0};
        tbl[13] = '{0, 4'd0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0};

        // reset state
        #7;
        chk("rst_arb_req", ifc.arb_req, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_job_ready", ifc.job_ready, 1);
        chk("rst_xfer_valid", ifc.xfer_valid, 0);
        chk("rst_wait_cnt", ifc.wait_cnt, 0);
        chk("rst_starve", ifc.starve, 0);
        step();
        arb_rst_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].len, tbl[i].data, tbl[i].gnt);
            chk($sformatf("tbl%0d_arb_req", i), ifc.arb_req, tbl[i].req);
            chk($sformatf("tbl%0d_xfer_valid", i), ifc.xfer_valid, tbl[i].xv);
            chk($sformatf("tbl%0d_xfer_data", i), ifc.xfer_data, tbl[i].xd);
            chk($sformatf("tbl%0d_xfer_last", i), ifc.xfer_last, tbl[i].xl);
            chk($sformatf("tbl%0d_busy", i), ifc.busy, tbl[i].busy);
            chk($sformatf("tbl%0d_wait_cnt", i), ifc.wait_cnt, tbl[i].wt);
            step();
        end

        // pre-emption: grant withdrawn for 3 cycles after beat 1
        drive(1, 4'd3, 8'h20, 0);
        step();
        nb = 0; stall = 0; req_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            bit g;
            g = 1;
            if (nb == 2 && stall < 3) begin
                g = 0;
                stall++;
            end
            drive(0, 0, 0, g);
            if (ifc.arb_req) req_cycles++;
            if (ifc.xfer_valid) begin
                bdata.push_back(ifc.xfer_data);
                blast.push_back(ifc.xfer_last);
                nb++;
            end
            step();
        end
        chk("preempt_beats", nb, 4);
        chk("preempt_req_cycles", req_cycles, 7);
        for (int i = 0; i < 4 && i < bdata.size(); i++) begin
            chk($sformatf("preempt_data%0d", i), bdata[i], 8'h20 + 8'(i));
            chk($sformatf("preempt_last%0d", i), blast[i], i == 3);
        end

        // FIFO fill with no grant, starvation, then drain
        drive(1, 4'd0, 8'hA0, 0);
        step();
        drive(0, 0, 0, 0);
        step();
        for (int k = 0; k < 20; k++) begin
            drive(k < 5, 4'd0, 8'h30 + 8'(k), 0);
            if (k == 3) chk("fill_ready_k3", ifc.job_ready, 1);
            if (k == 4) chk("fill_ready_k4", ifc.job_ready, 0);
            chk($sformatf("starve_wait_k%0d", k), ifc.wait_cnt, SE ? ((k < STARVE_MAX) ? k : STARVE_MAX) : 0);
            chk($sformatf("starve_flag_k%0d", k), ifc.starve, SE && (k >= STARVE_MAX));
            chk($sformatf("starve_noxfer_k%0d", k), ifc.xfer_valid, 0);
            step();
        end
        drive(0, 0, 0, 1);
        chk("starve_gnt_xfer_valid", ifc.xfer_valid, 1);
        chk("starve_gnt_xfer_data", ifc.xfer_data, 8'hA0);
        chk("starve_before_clear", ifc.starve, SE);
        step();
        drive(0, 0, 0, 1);
        chk("starve_cleared_wait", ifc.wait_cnt, 0);
        chk("starve_cleared_flag", ifc.starve, 0);
        chk("starve_gap_busy", ifc.busy, 1);
        step();
        nb = 0;
        for (int c = 0; c < 40; c++) begin
            drive(0, 0, 0, 1);
            if (ifc.xfer_valid) begin
                if (nb < 4) chk($sformatf("drain_data%0d", nb), ifc.xfer_data, 8'h30 + 8'(nb));
                nb++;
            end
            step();
        end
        chk("fifth_job_rejected", nb, 4);

        // reset mid-burst at beat 2 of 4, with another job still queued
        drive(1, 4'd3, 8'h50, 1);
        step();
        drive(1, 4'd0, 8'h77, 1);
        step();
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            drive(0, 0, 0, 1);
            if (ifc.xfer_valid && ifc.xfer_data == 8'h52) found = 1;
            else step();
        end
        chk("midburst_reached_beat2", found, 1);
        arb_rst_n = 1'b0;
        #1;
        chk("midrst_arb_req", ifc.arb_req, 0);
        chk("midrst_xfer_valid", ifc.xfer_valid, 0);
        chk("midrst_busy", ifc.busy, 0);
        chk("midrst_job_ready", ifc.job_ready, 1);
        step();
        arb_rst_n = 1'b1;
        nb = 0;
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 0, 1);
            if (ifc.xfer_valid || ifc.busy || ifc.arb_req) nb++;
            step();
        end
        chk("postrst_quiet_cycles_with_activity", nb, 0);
        drive(1, 4'd0, 8'h60, 1);
        step();
        found = 0;
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 0, 1);
            if (ifc.xfer_valid && ifc.xfer_data == 8'h60) found++;
            step();
        end
        chk("postrst_new_job_beat", found, 1);

        // randomized traffic against the model
        drive(0, 0, 0, 0);
        arb_rst_n = 1'b0;
        step();
        arb_rst_n = 1'b1;
        model_reset();
        for (int cyc = 0; cyc < 1200; cyc++) begin
            bit         v, g;
            logic [3:0] l;
            logic [7:0] d;
            v = $urandom_range(0, 1) == 1;
            l = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            d = 8'($urandom);
            g = ((cyc % 100) < 25) ? 1'b0 : ($urandom_range(0, 9) < 7);
            drive(v, l, d, g);
            model_check(g);
            step();
            model_edge(v, l, d, g);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/arb_client_ctrl.md
# arb_client_ctrl

Requester-side controller for the fixed-priority arbiter: one instance sits on each requester lane, queues local transfer jobs, drives the arbiter request line, and sequences data beats on the cycles it holds the grant. It is the counterpart to the arbiter's registered one-cycle grant. A multi-beat job may be pre-empted mid-burst by a higher-priority lane, so the controller must tolerate grants that drop and resume.

## Interface
- DEPTH, 4: job FIFO entries; power of two, ≥2
- LEN_W, 4: job length field width; beats = job_len+1
- DATA_W, 8: beat data width
- STARVE_MAX, 15: wait-cycle threshold for starvation flag; < 2^8

Clock and reset (already decided): reset arb_rst_n, asynchronous, active-low; clock arb_clk.
- arb_clk  in  1  clock
- arb_rst_n  in  1  async active-low reset
- job_valid  in  1  job offered
- job_ready  out  1  FIFO can accept; = !full
- job_len  in  LEN_W  beats minus one
- job_data  in  DATA_W  base data value
- arb_req  out  1  request to arbiter, registered
- arb_gnt  in  1  grant from arbiter, registered on arbiter side
- xfer_valid  out  1  beat transferred this cycle
- xfer_data  out  DATA_W  beat data
- xfer_last  out  1  final beat of job
- busy  out  1  state != IDLE
- starve  out  1  wait threshold reached, registered
- wait_cnt  out  8  consecutive ungranted request cycles

## Operation
- Job FIFO: push on job_valid && job_ready. Stores {len, data}. Push is blocked when full, even with a same-cycle pop. Pop occurs only on the IDLE→ACTIVE transition.
- FSM states:
  - IDLE: arb_req=0. If the FIFO is non-empty, pop the head, load beat_cnt=0, len, and base, set arb_req←1, and go to ACTIVE.
  - ACTIVE: arb_req=1.
    - A beat occurs in any cycle with arb_req && arb_gnt.
    - Beat: xfer_valid=1, xfer_data=base+beat_cnt (mod 2^DATA_W), xfer_last=(beat_cnt==len). At the edge, beat_cnt increments.
    - If the beat was last, arb_req←0 and go to GAP.
    - Cycles without gnt stall; beat_cnt holds.
  - GAP: arb_req=0 for exactly one cycle. The stale grant the arbiter issues for the last sampled request is ignored, with no beat. Then go to IDLE.
- xfer_valid/xfer_data/xfer_last are combinational from state registers and arb_gnt. They are 0 outside ACTIVE.
- arb_gnt while arb_req=0 is always ignored.
- Starvation:
  - wait_cnt increments each cycle in ACTIVE with !arb_gnt, saturating at STARVE_MAX.
  - It clears on any beat and in IDLE/GAP.
  - starve is registered: it goes high at the edge where wait_cnt reaches STARVE_MAX and stays high until the next beat clears it.
- Reset (also mid-burst): FIFO emptied. arb_req, xfer_*, busy, starve, wait_cnt = 0, job_ready=1, state IDLE. The in-flight job is discarded.

## Timing
- Job accepted at edge E0 into an empty FIFO while IDLE:
  - Pop at E1; arb_req high after E1.
  - Arbiter grants at E2; first beat is visible in cycle E2→E3 and counted at E3.
- Uncontested N-beat job: beats in N consecutive cycles, arb_req high for N+1 cycles, then 1 GAP cycle. Next pop is 2 cycles after the last beat edge.
- Pre-emption: gnt low for k cycles adds k cycles. Data resumes at the same beat_cnt.
- job_len=0: single beat, xfer_last=1 on it.
- job_len=2^LEN_W−1: 2^LEN_W beats, beat_cnt width LEN_W+1 or compare before wrap. beat_cnt must not wrap early.

## Configuration
- ARB_CLIENT_STARVE_EN:
  - Defined: wait counter and starve flag as above.
  - Undefined: counter logic removed; wait_cnt and starve tied to 0. All other behaviour is identical.

## Structure
- Shared package arb_client_pkg: state enum (IDLE, ACTIVE, GAP), job struct {len, data} typedef, wait_cnt width constant.
- One sub-module, arb_client_fifo: synchronous DEPTH-entry FIFO with count-based full/empty and the block-push-when-full rule.

## Test plan
- Reset, then a job len=0 data=0x10 with gnt mirroring req one cycle late → one beat data 0x10 with last=1, arb_req high 2 cycles, then GAP; busy back to 0 after 4 edges from accept.
- Job len=3 data=0xFE, gnt held high → beats 0xFE,0xFF,0x00,0x01, last only on 0x01; stale gnt in GAP gives no xfer_valid.
- Job len=3, gnt dropped for 3 cycles after beat 1 → beats resume at base+2, total 4 beats, no duplicates.
- Push 4 jobs back-to-back with gnt=0 → job_ready low after 4th; 5th job_valid is not accepted; wait_cnt saturates at 15, starve=1; first gnt clears both.
- Assert arb_rst_n low mid-burst (beat 2 of 4) → arb_req, xfer_valid, busy are 0 immediately; FIFO empty after release; no beats until a new job is pushed.
- Build without ARB_CLIENT_STARVE_EN, gnt=0 for 20 cycles → starve=0, wait_cnt=0 throughout.
